// File: rtl/sdff_pipe_bank.sv
// rtl/sdff_pipe_bank.sv - NCH-channel bank of sync-reset delay lines with per-stage valid tracking
// Optional macro SDFF_PIPE_OCC_EN adds the per-channel occupancy count output OCC.
module sdff_pipe_bank #(
    parameter int WIDTH   = 1,
    parameter int DEPTH   = 2,
    parameter int NCH     = 4,
    parameter     RST_VAL = 0,
    parameter int CE_MODE = 0
) (
    input  logic                   C,
    input  logic                   R,
    input  logic [NCH*WIDTH-1:0]   D,
    input  logic [NCH-1:0]         E,
    input  logic [NCH-1:0]         SR,
    output logic [NCH*WIDTH-1:0]   Q,
`ifdef SDFF_PIPE_OCC_EN
    output logic [NCH*$clog2(DEPTH+1)-1:0] OCC,
`endif
    output logic [NCH-1:0]         QV
);

    localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);
`ifdef SDFF_PIPE_OCC_EN
    localparam int OW = $clog2(DEPTH+1);
`endif

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [DEPTH-1:0][WIDTH-1:0] s_q, s_d;
        logic [DEPTH-1:0]            v_q, v_d;
        logic                        clr;
        logic                        shift;

        // In CE mode the channel reset is qualified by the enable; shift never
        // happens while SR is asserted in either mode.
        assign clr   = (CE_MODE != 0) ? (E[k] & SR[k]) : SR[k];
        assign shift = E[k] & ~SR[k];

        always_comb begin
            s_d = s_q;
            v_d = v_q;
            if (clr) begin
                s_d = {DEPTH{RST_W}};
                v_d = '0;
            end else if (shift) begin
                s_d[0] = D[k*WIDTH +: WIDTH];
                v_d[0] = 1'b1;
                for (int i = 1; i < DEPTH; i++) begin
                    s_d[i] = s_q[i-1];
                    v_d[i] = v_q[i-1];
                end
            end
        end

        always_ff @(posedge C) begin
            if (!R) begin
                s_q <= {DEPTH{RST_W}};
                v_q <= '0;
            end else begin
                s_q <= s_d;
                v_q <= v_d;
            end
        end

        assign Q[k*WIDTH +: WIDTH] = s_q[DEPTH-1];
        assign QV[k]               = v_q[DEPTH-1];

`ifdef SDFF_PIPE_OCC_EN
        logic [OW-1:0] occ_q, occ_d;

        // Count tracks popcount(v): a shift only adds a valid word when the
        // last stage is not already dropping one off the end.
        always_comb begin
            occ_d = occ_q;
            if (clr) begin
                occ_d = '0;
            end else if (shift && !v_q[DEPTH-1]) begin
                occ_d = occ_q + OW'(1);
            end
        end

        always_ff @(posedge C) begin
            if (!R) begin
                occ_q <= '0;
            end else begin
                occ_q <= occ_d;
            end
        end

        assign OCC[k*OW +: OW] = occ_q;
`endif
    end

endmodule

// File: doc/sdff_pipe_bank.md
# sdff_pipe_bank

Multi-channel, parametrised bank of synchronous-reset delay lines built from the sync-reset flop primitives that dfflegalize maps (SDFF, SDFFE, SDFFCE). Each channel is a DEPTH-stage shift register with its own clock enable, synchronous reset and per-stage valid tracking. A compile-time mode parameter selects reset-over-enable (SDFFE) or enable-gated reset (SDFFCE) semantics. The bank sits in the techmap regression designs as the parametrised stress block for sync-reset legalisation across widths, depths and reset values.

## Interface
- WIDTH, 1, data bits per channel (>=1)
- DEPTH, 2, stages per channel (>=1)
- NCH, 4, number of independent channels (>=1)
- RST_VAL, 0, WIDTH-bit value loaded into every data stage on any reset
- CE_MODE, 0, 0 = channel reset overrides enable (SDFFE); 1 = channel reset acts only when enabled (SDFFCE)

- C  in  1  clock, all state updates on rising edge
- R  in  1  global reset, synchronous, active-low
- D  in  NCH*WIDTH  channel data in, channel k at [k*WIDTH +: WIDTH]
- E  in  NCH  per-channel shift enable, active-high
- SR  in  NCH  per-channel synchronous reset, active-high
- Q  out  NCH*WIDTH  last-stage data per channel
- QV  out  NCH  last-stage valid per channel
- OCC  out  NCH*$clog2(DEPTH+1)  valid-stage count per channel (only with SDFF_PIPE_OCC_EN)

## Operation
- Per channel: data stages s[0..DEPTH-1], valid bits v[0..DEPTH-1]; Q = s[DEPTH-1], QV = v[DEPTH-1].
- Priority at each rising edge of C, per channel k:
  - R==0: all s = RST_VAL, all v = 0, OCC = 0, every channel, regardless of E/SR/CE_MODE.
  - CE_MODE=0: SR[k]=1 -> clear channel (s=RST_VAL, v=0); else E[k]=1 -> shift; else hold.
  - CE_MODE=1: E[k]=1 and SR[k]=1 -> clear; E[k]=1 and SR[k]=0 -> shift; E[k]=0 -> hold (SR ignored).
- Shift: s[0]<=D[k], s[i]<=s[i-1]; v[0]<=1, v[i]<=v[i-1].
- Channels are fully independent; no cross-channel state.
- RST_VAL wider/narrower than WIDTH: truncated/zero-extended to WIDTH.
- X on SR while R==0: no effect on state (global reset dominates).

## Timing
- Reset values: Q = RST_VAL replicated per channel, QV = 0, OCC = 0.
- Latency: D sampled on an enabled edge appears on Q after DEPTH enabled edges of that channel; with E held high, exactly DEPTH cycles.
- QV rises on the same edge Q first carries a shifted-in word; stays 1 while no clear occurs.
- Hold cycles (E=0, no applicable reset) freeze all stages and OCC; no bubble insertion.
- Clear takes effect on the edge it is sampled; next enabled edge loads D into s[0] normally.
- DEPTH=1: Q/QV are single registers, behaviour identical to one SDFFE/SDFFCE per bit.
- Reset asserted mid-stream: all in-flight data discarded on that edge; no partial flush.

## Configuration
- SDFF_PIPE_OCC_EN defined: OCC port present; per channel a registered counter of set v bits. On shift: +1 if v[DEPTH-1]==0, unchanged if 1 (saturates at DEPTH). On clear/global reset: 0. Hold: unchanged. OCC always equals popcount(v).
- Not defined: OCC port and counters absent; all other behaviour identical.

## Test plan
- Global reset: WIDTH=4, RST_VAL=4'hA, R=0 one cycle with E=1, SR=0 -> Q = 0xAAAA (NCH=4), QV = 0, OCC = 0.
- Latency: DEPTH=3, ch0 E=1, D=1,2,3,4 on consecutive cycles after reset -> Q ch0 = 1 on 3rd edge, QV ch0 rises same edge, then 2,3,4; OCC ch0 counts 1,2,3,3.
- CE_MODE=0 priority: ch1 filled, SR[1]=1 with E[1]=0 -> next edge Q ch1 = RST_VAL, QV[1]=0, OCC[1]=0.
- CE_MODE=1 priority: ch1 filled with 5, SR[1]=1, E[1]=0 for 3 cycles -> Q ch1 stays 5, QV[1]=1; then E[1]=1, SR[1]=1 -> cleared on that edge.
- Independence/hold: ch2 E toggling 1,0,1,0 with D=7,8,9,10, DEPTH=2 -> Q ch2 = 7 after 2nd enabled edge (edge 3), ch0/ch3 unaffected by SR[2]=1.
- Mid-stream reset: R=0 one cycle while all channels full and E=1 -> all cleared; on the next cycle with R=1, E=1, D=3, s[0]=3 and Q=RST_VAL until DEPTH edges pass.
